// File: rtl/mux_rotate4_pkg.sv
// Shared types and defaults for the four-lane rotating selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_rotate4_pkg;

    // Default lane width in bits.
    localparam int WIDTH_DEF = 8;

    // Number of lanes being rotated.
    localparam int LANES = 4;

    // Rotation amount, 0..3.
    typedef logic [1:0] rot_t;

    // Input lane feeding output lane k for a given rotation.
    // The index wraps modulo 4, so every output always has a source.
    function automatic rot_t src_lane(input rot_t k, input rot_t sel);
        return rot_t'(k + sel);
    endfunction

endpackage

// File: rtl/mux_rotate4_mux4_1.sv
// Combinational 4:1 selector of WIDTH bits, one per output lane.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the output follows the inputs continuously.
module mux4_1
    import mux_rotate4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  rot_t             sel,
    output logic [WIDTH-1:0] y
);

    // Pick one of the four candidates; an unknown sel falls back to d0.
    always_comb begin
        y = d0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux_rotate4.sv
// Four-lane barrel crossbar: output lane k takes input lane (k + sel) mod 4.
// Latency: one cycle; sel and data are sampled together on the rising edge.
// Backpressure: none; every edge outside reset loads new values.
module mux_rotate4
    import mux_rotate4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  rot_t             sel,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic [WIDTH-1:0] inp3,
    input  logic [WIDTH-1:0] inp4,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4
);

    logic [WIDTH-1:0] lane_dat [LANES];
    logic [WIDTH-1:0] mux_dat  [LANES];
    logic [WIDTH-1:0] out_q    [LANES];

    assign lane_dat[0] = inp1;
    assign lane_dat[1] = inp2;
    assign lane_dat[2] = inp3;
    assign lane_dat[3] = inp4;

    // Each selector sees the inputs pre-rotated by its own lane index, so a
    // shared sel value yields the (k + sel) mod 4 mapping on every lane.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mux4_1 #(
            .WIDTH (WIDTH)
        ) u_mux (
            .d0  (lane_dat[k]),
            .d1  (lane_dat[(k + 1) % LANES]),
            .d2  (lane_dat[(k + 2) % LANES]),
            .d3  (lane_dat[(k + 3) % LANES]),
            .sel (sel),
            .y   (mux_dat[k])
        );
    end

    // Output registers: clear immediately on reset, otherwise capture every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                out_q[k] <= mux_dat[k];
            end
        end
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];
    assign out3 = out_q[2];
    assign out4 = out_q[3];

endmodule

// File: tb/tb_mux_rotate4.sv
// Self-checking bench for mux_rotate4: directed vector table plus
// hand-written sequences for reset, latency and back-to-back rotation.
module tb_mux_rotate4;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   sel;
    logic [W-1:0] inp1, inp2, inp3, inp4;
    logic [W-1:0] out1, out2, out3, out4;

    int checks;
    int errors;

    mux_rotate4 #(
        .WIDTH (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .inp1 (inp1),
        .inp2 (inp2),
        .inp3 (inp3),
        .inp4 (inp4),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3),
        .out4 (out4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   sel;
        logic [W-1:0] i1, i2, i3, i4;
        logic [W-1:0] e1, e2, e3, e4;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2,
                        input logic [W-1:0] e3, input logic [W-1:0] e4);
        chk({name, ".out1"}, out1, e1);
        chk({name, ".out2"}, out2, e2);
        chk({name, ".out3"}, out3, e3);
        chk({name, ".out4"}, out4, e4);
    endtask

    task automatic drive(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d);
        sel  = s;
        inp1 = a;
        inp2 = b;
        inp3 = c;
        inp4 = d;
    endtask

    initial begin
        logic [W-1:0] lanes [4];
        logic [W-1:0] exp   [4];

        checks = 0;
        errors = 0;

        vecs[0] = '{2'd0, 8'hDF, 8'hAC, 8'h3C, 8'h9B, 8'hDF, 8'hAC, 8'h3C, 8'h9B};
        vecs[1] = '{2'd1, 8'hDF, 8'hAC, 8'h3C, 8'h9B, 8'hAC, 8'h3C, 8'h9B, 8'hDF};
        vecs[2] = '{2'd2, 8'hDF, 8'hAC, 8'h3C, 8'h9B, 8'h3C, 8'h9B, 8'hDF, 8'hAC};
        vecs[3] = '{2'd3, 8'hDF, 8'hAC, 8'h3C, 8'h9B, 8'h9B, 8'hDF, 8'hAC, 8'h3C};

        // Reset held from time zero: outputs must be clear.
        rst = 1'b1;
        drive(2'd0, 8'hDF, 8'hAC, 8'h3C, 8'h9B);
        #1;
        chk4("reset_init", 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk4("reset_hold", 8'h00, 8'h00, 8'h00, 8'h00);

        // Release reset away from the edge; first capture on next edge.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk4("first_capture", 8'hDF, 8'hAC, 8'h3C, 8'h9B);

        // Table-driven rotations.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(vecs[i].sel, vecs[i].i1, vecs[i].i2, vecs[i].i3, vecs[i].i4);
            @(posedge clk); #1;
            chk4($sformatf("vec%0d_sel%0d", i, vecs[i].sel),
                 vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4);
        end

        // Latency: load sel=0, then switch sel and data together.
        @(negedge clk);
        drive(2'd0, 8'hDF, 8'hAC, 8'h3C, 8'h9B);
        @(posedge clk); #1;
        chk4("lat_pre", 8'hDF, 8'hAC, 8'h3C, 8'h9B);
        @(negedge clk);
        drive(2'd3, 8'h11, 8'h22, 8'h33, 8'h44);
        #2;
        chk4("lat_hold", 8'hDF, 8'hAC, 8'h3C, 8'h9B);
        @(posedge clk); #1;
        chk4("lat_new", 8'h44, 8'h11, 8'h22, 8'h33);

        // Back-to-back sel changes, one result per cycle.
        lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33; lanes[3] = 8'h44;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            lanes[0] = lanes[0] + 8'h01;
            drive(2'(s), lanes[0], lanes[1], lanes[2], lanes[3]);
            for (int k = 0; k < 4; k++) exp[k] = lanes[(k + s) % 4];
            @(posedge clk); #1;
            chk4($sformatf("b2b_sel%0d", s), exp[0], exp[1], exp[2], exp[3]);
        end

        // Mid-operation reset: clear immediately, pending capture dropped.
        @(negedge clk);
        drive(2'd1, 8'h55, 8'h66, 8'h77, 8'h88);
        #2;
        rst = 1'b1;
        #1;
        chk4("midrst_async", 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk4("midrst_hold", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk4("midrst_release", 8'h00, 8'h00, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk4("midrst_recover", 8'h66, 8'h77, 8'h88, 8'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rotate4.md
Name: mux_rotate4

Overview:
- 4-input, 4-output rotating selector (barrel crossbar) for byte-wide datapath lanes.
- A 2-bit select rotates the input-to-output lane mapping; all outputs are registered.
- Used where four operand lanes must be re-aligned by a runtime offset before the next pipeline stage.

Parameters:
- WIDTH, 8, bit width of every data input and output lane.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sel  input  2  rotation amount, 0..3.
- inp1  input  WIDTH  lane 0 data.
- inp2  input  WIDTH  lane 1 data.
- inp3  input  WIDTH  lane 2 data.
- inp4  input  WIDTH  lane 3 data.
- out1  output  WIDTH  registered output, lane 0.
- out2  output  WIDTH  registered output, lane 1.
- out3  output  WIDTH  registered output, lane 2.
- out4  output  WIDTH  registered output, lane 3.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset: when rst is asserted, out1..out4 go to 0 immediately, without waiting for a clock edge. They stay at 0 while rst is high. The first capture happens at the first rising clk edge after rst deasserts.
- Lane mapping: number inputs inp1..inp4 as lanes 0..3. Output lane k takes input lane (k + sel) mod 4.
  - sel=0: out1..out4 = inp1, inp2, inp3, inp4 (identity).
  - sel=1: out1..out4 = inp2, inp3, inp4, inp1.
  - sel=2: out1..out4 = inp3, inp4, inp1, inp2.
  - sel=3: out1..out4 = inp4, inp1, inp2, inp3.
- Latency: exactly one cycle. sel and inp1..inp4 are sampled together at a rising clk edge, and the mapped values appear on out1..out4 immediately after that edge.
- No handshake. Every rising edge outside reset loads new values, so outputs track inputs with a one-cycle lag.
- Wrap-around: the index sum is taken mod 4, so no output is ever undriven or X for a defined sel.
- X or Z on sel: outputs are not specified. Simulation must not hang.
- Data is passed through unmodified. No arithmetic, sign handling or width conversion is performed.
- Mid-operation reset: outputs clear asynchronously. The pending capture is discarded. There is no retained state other than the output registers.

Decomposition:
- Shared package: WIDTH default and a 2-bit sel typedef (rot_t).
- One natural sub-module, mux4_1: a combinational 4:1 selector of WIDTH bits. It is instantiated four times with inputs rotated per lane.
- The parent module holds the four output registers and the reset logic.

Test Plan:
- Reset: assert rst mid-cycle with any inputs -> out1..out4 = 0x00 immediately, with no clock edge needed. They stay 0 until the first edge after rst falls.
- inp1..inp4 = 0xDF, 0xAC, 0x3C, 0x9B, sel=0 -> after one edge, out1..out4 = DF, AC, 3C, 9B.
- Same inputs, sel=1 -> out1..out4 = AC, 3C, 9B, DF.
- Same inputs, sel=2 -> out1..out4 = 3C, 9B, DF, AC.
- Same inputs, sel=3 -> out1..out4 = 9B, DF, AC, 3C.
- Latency check: change sel from 0 to 3 and inputs to 0x11, 0x22, 0x33, 0x44 on the same cycle. Outputs keep their old values until the next edge, then become 44, 11, 22, 33. Back-to-back sel changes every cycle must produce one correct result per cycle.
